// File: rtl/if_fetch_pkg.sv
// Shared fetch-stage definitions: NOP encoding, boot vector and FSM state encodings.
package if_fetch_pkg;

  localparam logic [15:0] INST_NOP        = 16'h6000;
  localparam logic [12:0] IF_RESET_VECTOR = 13'h0000;

  typedef enum logic [1:0] {
    IF_ST_BOOT  = 2'd0,
    IF_ST_RUN   = 2'd1,
    IF_ST_STALL = 2'd2
  } if_state_e;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/if_skid_buf.sv
// Skid buffer for the fetch stage: captures ROM data on a stall and replays it while stalled.
module if_skid_buf
  import if_fetch_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH  = 16,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = DATA_WIDTH'(INST_NOP)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  sel,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] buf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q <= RESET_VALUE;
    end else if (load) begin
      buf_q <= din;
    end
  end

  assign dout = sel ? buf_q : din;

endmodule

// File: rtl/if_fetch.sv
// PC generation / instruction fetch for the J1-style CPU, driving a 1-cycle synchronous ROM.
// Optional performance counters enabled by defining IF_PERF_CNT_EN.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH   = 13,
  parameter int unsigned           DATA_WIDTH   = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = ADDR_WIDTH'(IF_RESET_VECTOR),
  parameter int unsigned           BOOT_CYCLES  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  jump_flag_i,
  input  logic [ADDR_WIDTH-1:0] jump_addr_i,
  input  logic                  hold_flag_i,
  output logic                  rom_ce_o,
  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  input  logic [DATA_WIDTH-1:0] rom_data_i,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic [DATA_WIDTH-1:0] inst_o,
  output logic                  inst_valid_o
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]           fetch_cnt_o,
  output logic [31:0]           stall_cnt_o
`endif
);

  localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES);

  if_state_e             state_q, state_d;
  logic [3:0]            boot_cnt_q, boot_cnt_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d, pc_inc;
  logic                  issued_q;
  logic                  buf_load;
  logic [DATA_WIDTH-1:0] skid_dout;

  assign pc_inc = pc_q + ADDR_WIDTH'(1);

  always_comb begin
    state_d    = state_q;
    boot_cnt_d = boot_cnt_q;
    pc_d       = pc_q;
    rom_ce_o   = 1'b0;
    rom_addr_o = pc_q;
    buf_load   = 1'b0;
    case (state_q)
      IF_ST_BOOT: begin
        rom_addr_o = RESET_VECTOR;
        // rst_n gate keeps the ROM idle during reset even when BOOT_CYCLES is 0
        if (boot_cnt_q == BOOT_LAST && rst_n) begin
          rom_ce_o = 1'b1;
          pc_d     = RESET_VECTOR;
          state_d  = IF_ST_RUN;
        end else begin
          boot_cnt_d = boot_cnt_q + 4'd1;
        end
      end
      IF_ST_RUN: begin
        if (jump_flag_i) begin
          rom_ce_o   = 1'b1;
          rom_addr_o = jump_addr_i;
          pc_d       = jump_addr_i;
        end else if (hold_flag_i) begin
          buf_load = 1'b1;
          state_d  = IF_ST_STALL;
        end else begin
          rom_ce_o   = 1'b1;
          rom_addr_o = pc_inc;
          pc_d       = pc_inc;
        end
      end
      IF_ST_STALL: begin
        if (jump_flag_i) begin
          rom_ce_o   = 1'b1;
          rom_addr_o = jump_addr_i;
          pc_d       = jump_addr_i;
          state_d    = IF_ST_RUN;
        end else if (!hold_flag_i) begin
          rom_ce_o   = 1'b1;
          rom_addr_o = pc_inc;
          pc_d       = pc_inc;
          state_d    = IF_ST_RUN;
        end
      end
      default: state_d = IF_ST_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IF_ST_BOOT;
      boot_cnt_q <= '0;
      pc_q       <= RESET_VECTOR;
      issued_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
      pc_q       <= pc_d;
      issued_q   <= rom_ce_o;
    end
  end

  if_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .RESET_VALUE(DATA_WIDTH'(INST_NOP))
  ) u_skid_buf (
    .clk  (clk),
    .rst_n(rst_n),
    .load (buf_load),
    .sel  (state_q == IF_ST_STALL),
    .din  (rom_data_i),
    .dout (skid_dout)
  );

  assign pc_o         = pc_q;
  assign inst_o       = (state_q == IF_ST_BOOT) ? DATA_WIDTH'(INST_NOP) : skid_dout;
  assign inst_valid_o = (state_q == IF_ST_STALL) || ((state_q == IF_ST_RUN) && issued_q);

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_o <= '0;
      stall_cnt_o <= '0;
    end else begin
      if (rom_ce_o) fetch_cnt_o <= sat_inc32(fetch_cnt_o);
      if (state_q == IF_ST_STALL) stall_cnt_o <= sat_inc32(stall_cnt_o);
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Directed self-checking bench for if_fetch with a behavioural 1-cycle ROM (ROM[a] = {3'b111, a}).
module tb_if_fetch;

  localparam logic [15:0] NOP = 16'h6000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        jump_flag_i = 1'b0;
  logic [12:0] jump_addr_i = '0;
  logic        hold_flag_i = 1'b0;
  logic        rom_ce_o;
  logic [12:0] rom_addr_o;
  logic [15:0] rom_data_i = '0;
  logic [12:0] pc_o;
  logic [15:0] inst_o;
  logic        inst_valid_o;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_o, stall_cnt_o;
`endif

  int checks = 0;
  int failures = 0;

  if_fetch #(
    .ADDR_WIDTH  (13),
    .DATA_WIDTH  (16),
    .RESET_VECTOR(13'h0000),
    .BOOT_CYCLES (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .jump_flag_i (jump_flag_i),
    .jump_addr_i (jump_addr_i),
    .hold_flag_i (hold_flag_i),
    .rom_ce_o    (rom_ce_o),
    .rom_addr_o  (rom_addr_o),
    .rom_data_i  (rom_data_i),
    .pc_o        (pc_o),
    .inst_o      (inst_o),
    .inst_valid_o(inst_valid_o)
`ifdef IF_PERF_CNT_EN
    ,
    .fetch_cnt_o (fetch_cnt_o),
    .stall_cnt_o (stall_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rom_ce_o) rom_data_i <= {3'b111, rom_addr_o};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // addr is only compared when chk_addr is set (ROM address is a don't-care while idle)
  task automatic chk_all(input string tag, input logic ce, input logic chk_addr,
                         input logic [12:0] addr, input logic [12:0] pc,
                         input logic [15:0] inst, input logic valid);
    chk({tag, ".ce"}, 32'(rom_ce_o), 32'(ce));
    if (chk_addr) chk({tag, ".addr"}, 32'(rom_addr_o), 32'(addr));
    chk({tag, ".pc"}, 32'(pc_o), 32'(pc));
    chk({tag, ".inst"}, 32'(inst_o), 32'(inst));
    chk({tag, ".valid"}, 32'(inst_valid_o), 32'(valid));
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // reset state
    rst_n = 1'b0;
    #1;
    chk_all("reset", 1'b0, 1'b1, 13'h0000, 13'h0000, NOP, 1'b0);
    cyc();
    rst_n = 1'b1;
    #1;
    chk_all("boot0", 1'b0, 1'b0, 13'h0, 13'h0000, NOP, 1'b0);
    cyc(); #1;
    chk_all("boot1", 1'b0, 1'b0, 13'h0, 13'h0000, NOP, 1'b0);
    cyc(); #1;
    chk_all("boot_issue", 1'b1, 1'b1, 13'h0000, 13'h0000, NOP, 1'b0);
    cyc(); #1;
    chk_all("run0", 1'b1, 1'b1, 13'h0001, 13'h0000, 16'hE000, 1'b1);
    cyc(); #1;
    chk_all("run1", 1'b1, 1'b1, 13'h0002, 13'h0001, 16'hE001, 1'b1);
    cyc(); #1;
    chk_all("run2", 1'b1, 1'b1, 13'h0003, 13'h0002, 16'hE002, 1'b1);
    cyc(); #1;
    chk_all("run3", 1'b1, 1'b1, 13'h0004, 13'h0003, 16'hE003, 1'b1);
    cyc(); cyc();

    // jump to 0x100 from pc 5
    jump_flag_i = 1'b1; jump_addr_i = 13'h0100;
    #1;
    chk_all("jmp_issue", 1'b1, 1'b1, 13'h0100, 13'h0005, 16'hE005, 1'b1);
    cyc();
    jump_flag_i = 1'b0;
    #1;
    chk_all("jmp_tgt", 1'b1, 1'b1, 13'h0101, 13'h0100, 16'hE100, 1'b1);
    cyc(); #1;
    chk_all("jmp_next", 1'b1, 1'b1, 13'h0102, 13'h0101, 16'hE101, 1'b1);

    // reach pc 7 via jump to 6, then hold 3 cycles
    jump_flag_i = 1'b1; jump_addr_i = 13'h0006;
    cyc();
    jump_flag_i = 1'b0;
    cyc();
    hold_flag_i = 1'b1;
    #1;
    chk_all("hold0", 1'b0, 1'b0, 13'h0, 13'h0007, 16'hE007, 1'b1);
    cyc(); #1;
    chk_all("hold1", 1'b0, 1'b0, 13'h0, 13'h0007, 16'hE007, 1'b1);
    cyc(); #1;
    chk_all("hold2", 1'b0, 1'b0, 13'h0, 13'h0007, 16'hE007, 1'b1);
    cyc();
    hold_flag_i = 1'b0;
    #1;
    chk_all("release", 1'b1, 1'b1, 13'h0008, 13'h0007, 16'hE007, 1'b1);
    cyc(); #1;
    chk_all("after_rel", 1'b1, 1'b1, 13'h0009, 13'h0008, 16'hE008, 1'b1);

    // jump together with hold while stalled
    hold_flag_i = 1'b1;
    cyc();
    jump_flag_i = 1'b1; jump_addr_i = 13'h0040;
    #1;
    chk_all("stall_jmp", 1'b1, 1'b1, 13'h0040, 13'h0008, 16'hE008, 1'b1);
    cyc();
    jump_flag_i = 1'b0; hold_flag_i = 1'b0;
    #1;
    chk_all("stall_jmp_tgt", 1'b1, 1'b1, 13'h0041, 13'h0040, 16'hE040, 1'b1);

    // sequential wrap at top of address space
    jump_flag_i = 1'b1; jump_addr_i = 13'h1FFE;
    cyc();
    jump_flag_i = 1'b0;
    #1;
    chk_all("wrap0", 1'b1, 1'b1, 13'h1FFF, 13'h1FFE, 16'hFFFE, 1'b1);
    cyc(); #1;
    chk_all("wrap1", 1'b1, 1'b1, 13'h0000, 13'h1FFF, 16'hFFFF, 1'b1);
    cyc(); #1;
    chk_all("wrap2", 1'b1, 1'b1, 13'h0001, 13'h0000, 16'hE000, 1'b1);
    cyc();

    // reset pulsed during STALL
    hold_flag_i = 1'b1;
    cyc(); #1;
    chk_all("pre_rst_stall", 1'b0, 1'b0, 13'h0, 13'h0001, 16'hE001, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_all("mid_rst", 1'b0, 1'b1, 13'h0000, 13'h0000, NOP, 1'b0);
`ifdef IF_PERF_CNT_EN
    chk("mid_rst.fetch_cnt", fetch_cnt_o, 32'd0);
    chk("mid_rst.stall_cnt", stall_cnt_o, 32'd0);
`endif
    hold_flag_i = 1'b0;
    cyc();
    rst_n = 1'b1;
    #1;
    chk_all("reboot0", 1'b0, 1'b0, 13'h0, 13'h0000, NOP, 1'b0);
    cyc(); #1;
    chk_all("reboot1", 1'b0, 1'b0, 13'h0, 13'h0000, NOP, 1'b0);
    cyc(); #1;
    chk_all("reboot_issue", 1'b1, 1'b1, 13'h0000, 13'h0000, NOP, 1'b0);
    cyc(); #1;
    chk_all("reboot_run0", 1'b1, 1'b1, 13'h0001, 13'h0000, 16'hE000, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- PC-generation and instruction-fetch stage of the J1-style 16-bit stack CPU; sits directly upstream of the IF/ID pipeline register.
- Drives the synchronous instruction ROM (one-cycle read latency).
- Presents {pc_o, inst_o, inst_valid_o} aligned to the same cycle for IF/ID capture.
- Accepts redirects from EX (jump) and stalls from the hazard logic, and gates ROM enable during stalls.

Parameters:
ADDR_WIDTH, 13, instruction address width (word addresses, 8K x 16 ROM)
DATA_WIDTH, 16, instruction width
RESET_VECTOR, 13'h0000, first fetch address after boot
BOOT_CYCLES, 2, idle cycles after reset release before the first ROM access (ROM init settle); legal range 0..15

Ports:
clk  in  1  system clock; all state on rising edge
rst_n  in  1  asynchronous active-low reset
jump_flag_i  in  1  redirect request from EX
jump_addr_i  in  ADDR_WIDTH  redirect target
hold_flag_i  in  1  stall from hazard/ctrl logic; freeze fetch
rom_ce_o  out  1  ROM read enable
rom_addr_o  out  ADDR_WIDTH  ROM read address (combinational from state and inputs)
rom_data_i  in  DATA_WIDTH  ROM data, valid one cycle after an access with rom_ce_o=1
pc_o  out  ADDR_WIDTH  address of inst_o
inst_o  out  DATA_WIDTH  fetched instruction
inst_valid_o  out  1  pc_o/inst_o hold a real fetched instruction

Behaviour:
- Registers:
  - state: BOOT, RUN, STALL
  - boot_cnt[3:0]
  - pc_q: address issued on the previous access
  - buf_q[DATA_WIDTH-1:0]: skid buffer
  - issued_q: an access was made last cycle
- Reset (async, rst_n=0):
  - state=BOOT, boot_cnt=0, pc_q=RESET_VECTOR, issued_q=0, buf_q=INST_NOP.
  - Outputs: rom_ce_o=0, rom_addr_o=RESET_VECTOR, pc_o=RESET_VECTOR, inst_o=INST_NOP, inst_valid_o=0.
- BOOT:
  - Counting: rom_ce_o=0, inst_valid_o=0, inst_o=INST_NOP; boot_cnt increments each cycle.
  - When boot_cnt==BOOT_CYCLES: issue rom_ce_o=1, rom_addr_o=RESET_VECTOR; pc_q<=RESET_VECTOR; issued_q<=1; next state RUN.
  - jump_flag_i and hold_flag_i are ignored in BOOT.
- RUN, output side: pc_o=pc_q, inst_o=rom_data_i, inst_valid_o=issued_q.
- RUN, next access, by priority:
  - jump_flag_i=1: rom_addr_o=jump_addr_i, rom_ce_o=1, pc_q<=jump_addr_i. The current inst_o is wrong-path; it is still presented with inst_valid_o=1, and IF/ID substitutes NOP. Jump beats hold.
  - hold_flag_i=1: rom_ce_o=0; buf_q<=rom_data_i; pc_q unchanged; next state STALL.
  - otherwise: rom_addr_o=pc_q+1 (modulo 2^ADDR_WIDTH, so 13'h1FFF wraps to 0), rom_ce_o=1, pc_q<=rom_addr_o.
- STALL:
  - Outputs: pc_o=pc_q, inst_o=buf_q, inst_valid_o=1; rom_ce_o=0 while hold_flag_i=1.
  - Release (hold_flag_i=0): rom_addr_o=pc_q+1, rom_ce_o=1, pc_q<=pc_q+1; next state RUN. inst_o=buf_q in the release cycle.
  - jump_flag_i=1 (with or without hold): rom_addr_o=jump_addr_i, rom_ce_o=1, pc_q<=jump_addr_i; next state RUN.
- Latency:
  - Redirect to target on inst_o: 1 cycle.
  - Sequential throughput: 1 instruction per cycle.
  - Hold release to next new instruction on inst_o: 1 cycle.
- Reset mid-operation: immediate return to reset values; the in-flight ROM result is discarded; a full BOOT sequence repeats.
- INST_NOP comes from the shared defines.

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- Defined: adds outputs fetch_cnt_o[31:0] and stall_cnt_o[31:0], both reset to 0.
  - fetch_cnt_o increments on every cycle with rom_ce_o=1.
  - stall_cnt_o increments on every cycle in STALL.
  - Both saturate at 32'hFFFFFFFF.
- Undefined: ports and logic are absent; the rest of the behaviour is identical.

Decomposition:
- Shared defines: INST_NOP, RESET_VECTOR default, and the state encodings IF_ST_BOOT=2'd0, IF_ST_RUN=2'd1, IF_ST_STALL=2'd2.
- Natural sub-module: if_skid_buf, holding buf_q with load/select and async reset. The PC/FSM logic stays in if_fetch.

Test Plan:
- Reset release with BOOT_CYCLES=2: rom_ce_o=0 for 2 cycles, then access at addr 0. Next cycle pc_o=0, inst_valid_o=1, inst_o=ROM[0]. Then pc_o steps 1, 2, 3 on consecutive cycles.
- Jump to 13'h0100 while pc_q=5: rom_addr_o=0x100 in the same cycle; next cycle pc_o=0x100, inst_o=ROM[0x100]; the following cycle pc_o=0x101.
- hold_flag_i high for 3 cycles at pc_q=7: rom_ce_o=0 for those 3 cycles; pc_o=7 and inst_o=ROM[7] stable for 4 cycles (3 stall plus release); then pc_o=8.
- Jump together with hold in STALL, target 0x40: redirect taken; next cycle pc_o=0x40, state RUN.
- Sequential fetch from 0x1FFE: pc_o follows 0x1FFE, 0x1FFF, 0x0000 (wrap).
- rst_n pulsed low during STALL: outputs return immediately to reset values and the BOOT sequence repeats. With IF_PERF_CNT_EN, both counters read 0.
